kbd_decoder: RTL
================

KBD_DECODER -- requirements
Module: kbd_decoder

Interface
REQ-001 CNT_W, 8, width of press_count.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 ps2_data  in  8  head byte of the PS/2 receiver FIFO.
REQ-005 ps2_ready  in  1  high when the receiver FIFO is non-empty.
REQ-006 ps2_nextdata_n  out  1  active-low one-cycle FIFO pop request.
REQ-007 key_valid  out  1  one-cycle pulse on each new make event.
REQ-008 key_release  out  1  one-cycle pulse when the held key is released.
REQ-009 key_code  out  8  scan code of the last make event, held until the next make.
REQ-010 key_ext  out  1  high if the last make carried an E0 prefix.
REQ-011 key_down  out  1  high while the last made key remains held.
REQ-012 key_ascii  out  8  ASCII of key_code; 0x00 if unmapped.
REQ-013 press_count  out  CNT_W  count of make events, auto-repeats excluded.

Function
REQ-014 Handshake: in the capture phase with ps2_ready=1 at cycle N, the block SHALL register ps2_data and drive ps2_nextdata_n=0 for exactly cycle N+1.
REQ-015 Cycle N+2 SHALL be a gap cycle: ps2_nextdata_n=1 and ps2_ready is ignored; capture resumes at N+3, giving a maximum of one byte per 3 cycles.
REQ-016 Prefix FSM states: IDLE, EXT, BRK, EXTBRK; each captured byte is decoded in cycle N+1.
REQ-017 Byte E0 in IDLE or EXT SHALL go to EXT; F0 in IDLE SHALL go to BRK; F0 in EXT SHALL go to EXTBRK.
REQ-018 Byte E0 or F0 in BRK or EXTBRK is a protocol error: go to IDLE, no output change.
REQ-019 Any other byte in IDLE or EXT is a make event; the FSM SHALL return to IDLE.
REQ-020 If key_down=1 and {ext,byte} equals {key_ext,key_code}, the make is an auto-repeat: no pulse, no count.
REQ-021 Otherwise a make SHALL load key_code=byte and key_ext=(state==EXT), set key_down=1, pulse key_valid in N+1, and increment press_count.
REQ-022 press_count SHALL wrap modulo 2^CNT_W.
REQ-023 Any other byte in BRK or EXTBRK is a break event; the FSM SHALL return to IDLE.
REQ-024 If {ext,byte} matches the held key, a break SHALL clear key_down and pulse key_release; otherwise it is ignored.
REQ-025 key_ascii SHALL be a combinational function of key_code and key_ext: unshifted lowercase letters, digits, space 0x20, Enter 0x0D.
REQ-026 key_ascii SHALL be 0x00 when key_ext=1 or the code is unmapped.

Reset
REQ-027 resetn low SHALL immediately force: FSM IDLE, capture phase, ps2_nextdata_n=1, key_valid=0, key_release=0, key_code=0, key_ext=0, key_down=0, press_count=0.
REQ-028 Reset mid-sequence SHALL discard any pending prefix; the first byte after reset is decoded from IDLE.

Configuration
REQ-029 With KBD_ASCII_EN defined, the ASCII lookup SHALL be instantiated as in REQ-025 and REQ-026.
REQ-030 Without KBD_ASCII_EN, key_ascii SHALL be tied to 0x00 and no lookup logic SHALL exist.

Structure
REQ-031 Shared package kbd_pkg SHALL hold the FSM state enum and the constants SC_EXT=8'hE0 and SC_BRK=8'hF0.
REQ-032 The ASCII lookup SHALL be a sub-module kbd_ascii_rom (8-bit code in, 8-bit ASCII out, combinational).

Verification
REQ-033 Bytes 1C -> key_valid pulse, key_code=1C, key_ascii=61, key_down=1, press_count=1.
REQ-034 Bytes 1C,1C,1C -> one key_valid pulse only, press_count=1; then F0,1C -> key_release pulse, key_down=0.
REQ-035 Bytes E0,75 then E0,F0,75 -> key_ext=1, key_ascii=00, key_valid pulse, then key_release pulse, press_count=1.
REQ-036 Bytes F0 then resetn pulsed low, then 1C -> all outputs reset, then 1C decoded as a make, press_count=1.
REQ-037 Hold ps2_ready=1 for 30 cycles -> exactly 10 ps2_nextdata_n low pulses, each one cycle wide, spaced 3 cycles apart.
REQ-038 256 alternating makes 1C/32, each followed by its break -> press_count returns to 0x00.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard decoder.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK
    } kbd_state_t;

    typedef enum logic [1:0] {
        PH_CAPTURE,
        PH_POP,
        PH_GAP
    } kbd_phase_t;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

endpackage

// File: rtl/kbd_ascii_rom.sv
// Scan-code set 2 to ASCII lookup (unshifted letters, digits, space, Enter).
// Only present in builds that define KBD_ASCII_EN.
`ifdef KBD_ASCII_EN
module kbd_ascii_rom (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
    end

endmodule
`endif

// File: rtl/kbd_decoder.sv
// PS/2 scan-code decoder: pops bytes from the receiver FIFO and tracks make/break events.
// Define KBD_ASCII_EN to include the ASCII lookup; otherwise key_ascii is tied to zero.
module kbd_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    output logic             ps2_nextdata_n,
    output logic             key_valid,
    output logic             key_release,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] press_count
);
    import kbd_pkg::*;

    kbd_state_t       state_q, state_d;
    kbd_phase_t       phase_q, phase_d;
    logic             nextdata_n_d, valid_d, release_d, ext_d, down_d;
    logic [7:0]       code_d;
    logic [CNT_W-1:0] count_d;
    logic             is_prefix;

    assign is_prefix = (ps2_data == SC_EXT) || (ps2_data == SC_BRK);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            phase_q <= PH_CAPTURE;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Byte accepted in the capture phase is decoded at the same edge, so its
    // pop request and any event pulse appear together in the following cycle.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        nextdata_n_d = 1'b1;
        valid_d      = 1'b0;
        release_d    = 1'b0;
        code_d       = key_code;
        ext_d        = key_ext;
        down_d       = key_down;
        count_d      = press_count;
        unique case (phase_q)
            PH_CAPTURE: begin
                if (ps2_ready) begin
                    phase_d      = PH_POP;
                    nextdata_n_d = 1'b0;
                    unique case (state_q)
                        IDLE, EXT: begin
                            if (ps2_data == SC_EXT) begin
                                state_d = EXT;
                            end else if (ps2_data == SC_BRK) begin
                                state_d = (state_q == EXT) ? EXTBRK : BRK;
                            end else begin
                                state_d = IDLE;
                                if (!(key_down && ({state_q == EXT, ps2_data} == {key_ext, key_code}))) begin
                                    code_d  = ps2_data;
                                    ext_d   = (state_q == EXT);
                                    down_d  = 1'b1;
                                    valid_d = 1'b1;
                                    count_d = press_count + CNT_W'(1);
                                end
                            end
                        end
                        BRK, EXTBRK: begin
                            state_d = IDLE;
                            if (!is_prefix && key_down &&
                                ({state_q == EXTBRK, ps2_data} == {key_ext, key_code})) begin
                                down_d    = 1'b0;
                                release_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            PH_POP:  phase_d = PH_GAP;
            default: phase_d = PH_CAPTURE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps2_nextdata_n <= 1'b1;
            key_valid      <= 1'b0;
            key_release    <= 1'b0;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            key_down       <= 1'b0;
            press_count    <= '0;
        end else begin
            ps2_nextdata_n <= nextdata_n_d;
            key_valid      <= valid_d;
            key_release    <= release_d;
            key_code       <= code_d;
            key_ext        <= ext_d;
            key_down       <= down_d;
            press_count    <= count_d;
        end
    end

`ifdef KBD_ASCII_EN
    logic [7:0] rom_ascii;

    kbd_ascii_rom u_ascii_rom (
        .code  (key_code),
        .ascii (rom_ascii)
    );

    assign key_ascii = key_ext ? 8'h00 : rom_ascii;
`else
    assign key_ascii = 8'h00;
`endif

endmodule
